// File: rtl/mac_sequencer_pkg.sv
// rtl/mac_sequencer_pkg.sv - widths, mode codes, state encoding and config helpers for the MAC sequencer
package mac_sequencer_pkg;

  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_INT_WIDTH  = 4 * MAC_MIN_WIDTH;
  localparam int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH;
  localparam int MAC_CONF_WIDTH = 4;

  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic mode_ok(input logic [1:0] mode);
    return (mode == MAC_SINGLE) || (mode == MAC_DUAL) || (mode == MAC_QUAD);
  endfunction

  // conf field layout: {acc, reserved zero, mode}
  function automatic logic [MAC_CONF_WIDTH-1:0] conf_pack(input logic acc, input logic [1:0] mode);
    return {acc, 1'b0, mode};
  endfunction

endpackage

// File: rtl/mac_result_buf.sv
// rtl/mac_result_buf.sv - one-entry valid/ready result register that holds its contents while stalled
module mac_result_buf
  import mac_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid_i,
  input  logic [MAC_INT_WIDTH-1:0] push_data_i,
  input  logic                     push_last_i,
  input  logic                     push_err_i,
  input  logic                     pop_ready_i,
  output logic                     valid_o,
  output logic [MAC_INT_WIDTH-1:0] data_o,
  output logic                     last_o,
  output logic                     err_o
);

  logic                     valid_q, valid_d;
  logic [MAC_INT_WIDTH-1:0] data_q, data_d;
  logic                     last_q, last_d;
  logic                     err_q, err_d;

  // Caller only pushes when the entry is empty or being popped this cycle.
  always_comb begin
    valid_d = push_valid_i | (valid_q & ~pop_ready_i);
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    if (push_valid_i) begin
      data_d = push_data_i;
      last_d = push_last_i;
      err_d  = push_err_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign err_o   = err_q;

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sequences MAC jobs: command latch, accumulator clear, operand beats, result return
module mac_sequencer
  import mac_sequencer_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [1:0]                              cmd_mode,
  input  logic                                    cmd_acc,
  input  logic [MAC_ACC_WIDTH-1:0]                cmd_init,
  input  logic [7:0]                              cmd_len,
  input  logic                                    op_valid,
  output logic                                    op_ready,
  output logic                                    mac_en,
  output logic                                    mac_clr,
  output logic [MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
  input  logic [MAC_INT_WIDTH-1:0]                mac_c,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [MAC_INT_WIDTH-1:0]                res_data,
  output logic                                    res_last,
  output logic                                    res_err,
  output logic                                    busy
);

  state_e                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic                     acc_q, acc_d;
  logic [MAC_ACC_WIDTH-1:0] init_q, init_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     inflight_q, inflight_d;
  logic                     inflight_last_q, inflight_last_d;
  logic                     rdy_q;

  logic                     can_push;
  logic                     fire;
  logic                     push_valid;
  logic [MAC_INT_WIDTH-1:0] push_data;
  logic                     push_last;
  logic                     push_err;

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    acc_d           = acc_q;
    init_d          = init_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    inflight_d      = inflight_q;
    inflight_last_d = inflight_last_q;
    op_ready        = 1'b0;
    mac_clr         = 1'b0;
    fire            = 1'b0;
    push_valid      = 1'b0;
    push_data       = mac_c;
    push_last       = inflight_last_q;
    push_err        = 1'b0;
    can_push        = ~res_valid | res_ready;
    cmd_ready       = rdy_q & (state_q == ST_IDLE);

    // A multiply-only result is taken from mac_c on the cycle after its fire;
    // while it waits for buffer space mac_en stays low, so mac_c cannot move.
    if (inflight_q && can_push) begin
      push_valid = 1'b1;
      inflight_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          mode_d  = cmd_mode;
          acc_d   = cmd_acc;
          init_d  = cmd_init;
          len_d   = cmd_len;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d = len_q;
        if (mode_ok(mode_q)) begin
          mac_clr = 1'b1;
          state_d = ST_RUN;
        end else begin
          push_valid = 1'b1;
          push_data  = '0;
          push_last  = 1'b1;
          push_err   = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_RUN: begin
        op_ready = acc_q | can_push;
        fire     = op_valid & op_ready;
        if (fire) begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (!acc_q) begin
            inflight_d      = 1'b1;
            inflight_last_d = (cnt_q == 8'd0);
          end
          if (cnt_q == 8'd0) state_d = acc_q ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        push_valid = 1'b1;
        push_data  = mac_c;
        push_last  = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (res_valid && res_ready && res_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      mode_q          <= 2'd0;
      acc_q           <= 1'b0;
      init_q          <= '0;
      len_q           <= 8'd0;
      cnt_q           <= 8'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rdy_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      acc_q           <= acc_d;
      init_q          <= init_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rdy_q           <= 1'b1;
    end
  end

  assign mac_en  = fire;
  assign mac_cfg = {init_q, conf_pack(acc_q, mode_q)};
  assign busy    = (state_q != ST_IDLE);

  mac_result_buf u_res_buf (
    .clk          (clk),
    .rst_n        (rst),
    .push_valid_i (push_valid),
    .push_data_i  (push_data),
    .push_last_i  (push_last),
    .push_err_i   (push_err),
    .pop_ready_i  (res_ready),
    .valid_o      (res_valid),
    .data_o       (res_data),
    .last_o       (res_last),
    .err_o        (res_err)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer with a behavioural MAC model
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  logic                                    clk;
  logic                                    rst;
  logic                                    cmd_valid;
  logic                                    cmd_ready;
  logic [1:0]                              cmd_mode;
  logic                                    cmd_acc;
  logic [MAC_ACC_WIDTH-1:0]                cmd_init;
  logic [7:0]                              cmd_len;
  logic                                    op_valid;
  logic                                    op_ready;
  logic                                    mac_en;
  logic                                    mac_clr;
  logic [MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg;
  logic [MAC_INT_WIDTH-1:0]                mac_c;
  logic                                    res_valid;
  logic                                    res_ready;
  logic [MAC_INT_WIDTH-1:0]                res_data;
  logic                                    res_last;
  logic                                    res_err;
  logic                                    busy;

  mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_acc   (cmd_acc),
    .cmd_init  (cmd_init),
    .cmd_len   (cmd_len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_cfg   (mac_cfg),
    .mac_c     (mac_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .res_err   (res_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: clr loads init, en adds the current product (onto zero for multiply-only).
  logic [31:0] prod;
  logic [31:0] acc_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) acc_m <= '0;
    else if (mac_clr) acc_m <= mac_cfg[MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:MAC_CONF_WIDTH];
    else if (mac_en) acc_m <= (mac_cfg[MAC_CONF_WIDTH-1] ? acc_m : 32'd0) + prod;
  end
  assign mac_c = acc_m;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } res_t;

  res_t        rq[$];
  int          en_cnt    = 0;
  int          clr_cnt   = 0;
  int          hold_viol = 0;
  logic        hold_pend = 1'b0;
  logic [33:0] hold_val;
  int          checks    = 0;
  int          errors    = 0;
  logic        saw_drop;

  always begin
    @(negedge clk);
    #2;
    if (mac_en) en_cnt++;
    if (mac_clr) clr_cnt++;
    if (hold_pend && ({res_data, res_last, res_err} !== hold_val)) hold_viol++;
    hold_pend = res_valid && !res_ready;
    hold_val  = {res_data, res_last, res_err};
    if (res_valid && res_ready) rq.push_back('{res_data, res_last, res_err});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int idx, input logic [31:0] d, input logic l,
                           input logic e);
    if (idx < rq.size()) begin
      check_eq({tag, "_data"}, 64'(rq[idx].d), 64'(d));
      check_eq({tag, "_last"}, 64'(rq[idx].l), 64'(l));
      check_eq({tag, "_err"},  64'(rq[idx].e), 64'(e));
    end else begin
      check_eq({tag, "_present"}, 64'(rq.size()), 64'(idx + 1));
    end
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic a, input logic [31:0] init,
                          input logic [7:0] len);
    int g = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_acc   = a;
    cmd_init  = init;
    cmd_len   = len;
    #1;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_eq("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_beats(input int n, input logic [31:0] p0, input logic [31:0] step,
                           input int stall_at, input int stall_len);
    int i   = 0;
    int cyc = 0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      res_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      op_valid  = 1'b1;
      prod      = p0 + step * 32'(i);
      #1;
      if (op_ready) i++;
      else if (!res_ready) saw_drop = 1'b1;
      cyc++;
    end
    check_eq("beats_issued", 64'(i), 64'(n));
    @(negedge clk);
    op_valid  = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    #1;
    while (busy && g < 2000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  int en0, clr0, rb;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_acc   = 1'b0;
    cmd_init  = '0;
    cmd_len   = 8'd0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    prod      = '0;
    saw_drop  = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_busy",      64'(busy),      64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_mac_cfg",   64'(mac_cfg),   64'd0);
    rst = 1'b1;
    #1;
    check_eq("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    check_eq("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

    // Accumulate, single: 5 + 3*(2*3) = 23
    en0 = en_cnt; clr0 = clr_cnt; rb = rq.size();
    send_cmd(MAC_SINGLE, 1'b1, 32'd5, 8'd2);
    #1;
    check_eq("acc_cfg", 64'(mac_cfg), {28'd0, 32'd5, 4'b1000});
    run_beats(3, 32'd6, 32'd0, -1, 0);
    wait_idle("acc_idle");
    check_eq("acc_en_pulses",  64'(en_cnt - en0),    64'd3);
    check_eq("acc_clr_pulses", 64'(clr_cnt - clr0),  64'd1);
    check_eq("acc_res_count",  64'(rq.size() - rb),  64'd1);
    check_res("acc_res", rb, 32'd23, 1'b1, 1'b0);

    // Multiply-only, dual: lanes {2*3, 1*3} -> 0x0603 = 1539
    rb = rq.size();
    send_cmd(MAC_DUAL, 1'b0, 32'd0, 8'd0);
    #1;
    check_eq("dual_cfg", 64'(mac_cfg), {28'd0, 32'd0, 4'b0001});
    run_beats(1, 32'd1539, 32'd0, -1, 0);
    wait_idle("dual_idle");
    check_eq("dual_res_count", 64'(rq.size() - rb), 64'd1);
    check_res("dual_res", rb, 32'd1539, 1'b1, 1'b0);

    // Multiply-only, single, 4 beats with a 3-cycle result stall
    rb = rq.size(); saw_drop = 1'b0; en0 = en_cnt;
    send_cmd(MAC_SINGLE, 1'b0, 32'd0, 8'd3);
    run_beats(4, 32'd10, 32'd5, 2, 3);
    wait_idle("bp_idle");
    check_eq("bp_op_ready_dropped", 64'(saw_drop),        64'd1);
    check_eq("bp_en_pulses",        64'(en_cnt - en0),    64'd4);
    check_eq("bp_res_count",        64'(rq.size() - rb),  64'd4);
    check_eq("bp_hold_violations",  64'(hold_viol),       64'd0);
    check_res("bp_res0", rb,     32'd10, 1'b0, 1'b0);
    check_res("bp_res1", rb + 1, 32'd15, 1'b0, 1'b0);
    check_res("bp_res2", rb + 2, 32'd20, 1'b0, 1'b0);
    check_res("bp_res3", rb + 3, 32'd25, 1'b1, 1'b0);

    // Reset during RUN of an 8-beat job, then a clean job: 1 + 2*4 = 9
    send_cmd(MAC_QUAD, 1'b1, 32'd7, 8'd7);
    run_beats(3, 32'd1, 32'd0, -1, 0);
    op_valid = 1'b1;
    rst      = 1'b0;
    #1;
    check_eq("mid_rst_busy",      64'(busy),      64'd0);
    check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("mid_rst_op_ready",  64'(op_ready),  64'd0);
    check_eq("mid_rst_mac_en",    64'(mac_en),    64'd0);
    check_eq("mid_rst_mac_clr",   64'(mac_clr),   64'd0);
    check_eq("mid_rst_mac_cfg",   64'(mac_cfg),   64'd0);
    check_eq("mid_rst_res",       64'({res_valid, res_data, res_last, res_err}), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rb = rq.size(); en0 = en_cnt;
    send_cmd(MAC_SINGLE, 1'b1, 32'd1, 8'd1);
    run_beats(2, 32'd4, 32'd0, -1, 0);
    wait_idle("post_rst_idle");
    check_eq("post_rst_en_pulses", 64'(en_cnt - en0),   64'd2);
    check_eq("post_rst_res_count", 64'(rq.size() - rb), 64'd1);
    check_res("post_rst_res", rb, 32'd9, 1'b1, 1'b0);

    // Illegal mode: error result only, no MAC activity
    rb = rq.size(); en0 = en_cnt; clr0 = clr_cnt;
    send_cmd(2'b11, 1'b1, 32'd9, 8'd3);
    wait_idle("bad_idle");
    check_eq("bad_en_pulses",  64'(en_cnt - en0),   64'd0);
    check_eq("bad_clr_pulses", 64'(clr_cnt - clr0), 64'd0);
    check_eq("bad_res_count",  64'(rq.size() - rb), 64'd1);
    check_res("bad_res", rb, 32'd0, 1'b1, 1'b1);

    // 256-beat accumulate, product 1, init 0 -> 256
    rb = rq.size(); en0 = en_cnt;
    send_cmd(MAC_SINGLE, 1'b1, 32'd0, 8'd255);
    run_beats(256, 32'd1, 32'd0, -1, 0);
    wait_idle("long_idle");
    check_eq("long_en_pulses", 64'(en_cnt - en0),   64'd256);
    check_eq("long_res_count", 64'(rq.size() - rb), 64'd1);
    check_res("long_res", rb, 32'd256, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid in 1, cmd_ready out 1  job command handshake.
REQ-004 SHALL have ports: cmd_mode in 2 (`MAC_SINGLE/`MAC_DUAL/`MAC_QUAD), cmd_acc in 1 (1=accumulate, 0=multiply-only), cmd_init in `MAC_ACC_WIDTH (accumulator init), cmd_len in 8 (beats minus one).
REQ-005 SHALL have ports: op_valid in 1, op_ready out 1  operand-beat handshake; operand data routes directly to the MAC, not through this block.
REQ-006 SHALL have ports: mac_en out 1, mac_clr out 1, mac_cfg out `MAC_ACC_WIDTH+`MAC_CONF_WIDTH ({init, conf}), mac_c in `MAC_INT_WIDTH.
REQ-007 SHALL have ports: res_valid out 1, res_ready in 1, res_data out `MAC_INT_WIDTH, res_last out 1, res_err out 1, busy out 1.

Function
REQ-008 States SHALL be IDLE, LOAD, RUN, DRAIN, DONE; busy SHALL be high in every state except IDLE.
REQ-009 IDLE: cmd_ready=1; a cmd_valid&cmd_ready cycle latches mode/acc/init/len into registers and goes to LOAD.
REQ-010 conf field SHALL be {acc, 0, mode} with acc at bit `MAC_CONF_WIDTH-1; mac_cfg SHALL hold the latched value, stable from LOAD until the return to IDLE.
REQ-011 LOAD: mac_clr=1 for exactly one cycle (accumulator loads init); next state RUN; beat counter SHALL be set to len.
REQ-012 RUN: mac_en = op_valid & op_ready; each fire decrements the counter; the fire with counter==0 is the last beat.
REQ-013 Accumulate job: op_ready=1 throughout RUN; after the last beat, go to DRAIN for 1 cycle, then capture mac_c into res_data with res_valid=1 and res_last=1, then go to DONE.
REQ-014 Multiply-only job: every fire yields one result; mac_c SHALL be sampled on the cycle after the fire, and that value is res_data; res_last=1 only on the last beat's result.
REQ-015 Multiply-only backpressure: at most one beat in flight; op_ready = RUN & !inflight & (!res_valid | res_ready); no result SHALL be dropped or duplicated; throughput SHALL be 1 beat/cycle while res_ready=1.
REQ-016 res_data/res_last/res_err SHALL hold stable while res_valid & !res_ready.
REQ-017 DONE: wait for res_valid & res_ready on the last result, then go to IDLE; cmd_ready SHALL be 0 outside IDLE (no command overlap).
REQ-018 cmd_mode==2'b11: the command is accepted and no mac_en/mac_clr is issued; a single result SHALL be returned with res_data=0, res_err=1, res_last=1.
REQ-019 cmd_len==255 SHALL run 256 beats without counter wrap error.
REQ-020 mac_en SHALL be 0 in every state except RUN.

Reset
REQ-021 rst low SHALL asynchronously force IDLE and clear the counter, inflight, and latched config; the partial job is discarded.
REQ-022 During reset: cmd_ready=0, op_ready=0, mac_en=0, mac_clr=0, mac_cfg=0, res_valid=0, res_data=0, res_last=0, res_err=0, busy=0. cmd_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-023 Widths and mode codes SHALL come from mac_const.vh (`MAC_MIN_WIDTH, `MAC_INT_WIDTH, `MAC_ACC_WIDTH, `MAC_CONF_WIDTH, `MAC_SINGLE/DUAL/QUAD); state encodings SHALL be local parameters.
REQ-024 The block SHALL be a single module plus one sub-module, mac_result_buf: a one-entry valid/ready result register with hold-under-stall.

Verification (`MAC_MIN_WIDTH=8)
REQ-025 Accumulate, single mode, init=5, len=2, three beats A3=2,B3=3 -> exactly 3 mac_en pulses, one result 23 with res_last=1.
REQ-026 Multiply-only, dual mode, A2=1,A3=2,B3=3 for 1 beat -> res_data=1539, res_last=1.
REQ-027 Multiply-only, single mode, 4 beats, res_ready low for 3 cycles mid-job -> op_ready drops, 4 results in order, none lost or repeated.
REQ-028 Assert rst low during RUN of an 8-beat job -> all outputs 0 immediately; a following job completes correctly.
REQ-029 cmd_mode=2'b11 -> no mac_en/mac_clr pulses, one result with res_data=0, res_err=1, then IDLE.
REQ-030 cmd_len=255, accumulate, product 1 each beat, init 0 -> exactly 256 mac_en pulses, result 256.
